shared_adder_arbiter: RTL
=========================

Name: shared_adder_arbiter

Overview:
- Time-multiplexes one registered 32-bit add/subtract datapath between NUM_REQ requesters, e.g. PC+4, branch-target and address-calculation users.
- Sits between the fetch/execute control logic and the single shared adder.
- Round-robin arbitration with a one-cycle grant and a one-cycle registered result; each result is tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width.
- ID_W, $clog2(NUM_REQ), requester-ID width (derived; not overridden).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  NUM_REQ  per-requester request; level, held until granted.
- SubOp  input  NUM_REQ  per-requester: 1 = A-B, 0 = A+B.
- OpA  input  NUM_REQ*WIDTH  flattened operand A; requester i at [i*WIDTH +: WIDTH].
- OpB  input  NUM_REQ*WIDTH  flattened operand B, same packing.
- Grant  output  NUM_REQ  one-hot grant, combinational from Req and priority pointer.
- ResultValid  output  1  registered; result available this cycle.
- ResultId  output  ID_W  registered; requester that owns Result.
- Result  output  WIDTH  registered sum/difference, modulo 2^WIDTH.
- CarryOut  output  1  registered carry (add) / not-borrow (sub).

Behaviour:
- Reset (Reset=0, asynchronous): Grant=0, ResultValid=0, ResultId=0, Result=0, CarryOut=0, priority pointer=0.
- Arbitration: Grant = first asserted Req scanning from pointer upward with wrap (pointer, pointer+1 … NUM_REQ-1, 0 …). At most one Grant bit high. Grant=0 when Req=0.
- Grant is suppressed (all zero) while Reset=0.
- Capture: on a rising edge with Grant[i]=1, the block samples OpA[i], OpB[i] and SubOp[i]. Operands are don't-care in any other cycle.
- Latency: exactly 1 cycle. The edge after the grant cycle presents ResultValid=1, ResultId=i, Result, CarryOut.
- Throughput: one operation per cycle. Back-to-back grants give back-to-back ResultValid.
- With no grant in a cycle, ResultValid=0 next cycle; Result/ResultId/CarryOut hold their last values.
- Pointer update: on each granted edge, pointer <= (i+1) mod NUM_REQ. No grant leaves the pointer unchanged.
- Requester protocol: Req high until the cycle Grant[i] is seen. Keeping Req high after the grant requests another operation, which competes again behind the other requesters.
- Dropping Req before grant is legal; the request is simply withdrawn with no side effect.
- Arithmetic:
  - Add: {CarryOut,Result} = A + B.
  - Sub: {CarryOut,Result} = A + ~B + 1.
  - All unsigned modulo 2^WIDTH; wrap-around is not an error (0xFFFFFFFF+1 gives 0, CarryOut=1).
- Simultaneous events:
  - All Req high → strict rotation 0,1,2,3,0…
  - A single requester held high → granted every cycle.
- Reset mid-operation: an in-flight result is discarded (ResultValid forced 0); no grant is remembered across reset.

Optional Feature:
- SHARED_ADDER_OVF_EN
  - Defined: adds output Overflow (1 bit, registered, reset 0) = signed two's-complement overflow of the captured operation, aligned with ResultValid, held when idle.
  - Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package:
  - Default WIDTH (32) and NUM_REQ (4) constants.
  - Requester-ID localparams (REQ_PC=0, REQ_BRANCH=1, REQ_ADDR=2, REQ_ALU=3).
  - Op-encoding constants (OP_ADD=0, OP_SUB=1).
- One sub-module: rr_picker.
  - Purely combinational: Req + pointer → one-hot Grant + encoded winner ID.
  - Reusable by other arbiters.
- Top holds the pointer register, operand mux, adder and result registers.

Test Plan:
- Reset: hold Reset=0 with Req=4'b1111 → Grant=0, ResultValid=0, Result=0. Release → first Grant=4'b0001.
- Single add: Req=4'b0001, OpA[0]=0x00400000, OpB[0]=4 → next cycle ResultValid=1, ResultId=0, Result=0x00400004, CarryOut=0.
- Rotation: Req=4'b1111 for 8 cycles → Grant sequence 0001,0010,0100,1000,0001…; ResultId sequence 0,1,2,3,0… one cycle later.
- Wrap and sub:
  - Requester 2 adds 0xFFFFFFFF+1 → Result=0, CarryOut=1.
  - Requester 1 subtracts 5-7 → Result=0xFFFFFFFE, CarryOut=0.
- Fairness: Req=4'b1001 held, pointer at 0 → grants alternate 0001,1000,0001. Requester 3 is never starved.
- Mid-op reset: grant requester 1, assert Reset=0 before the next edge → ResultValid stays 0. With SHARED_ADDER_OVF_EN, 0x7FFFFFFF+1 gives Overflow=1.

Source files
------------

// File: rtl/shared_adder_arbiter_pkg.sv
// Shared constants for the shared adder arbiter: default sizes, requester IDs
// and the per-requester operation encoding.
package shared_adder_arbiter_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_NUM_REQ = 4;

    localparam int unsigned REQ_PC     = 0;
    localparam int unsigned REQ_BRANCH = 1;
    localparam int unsigned REQ_ADDR   = 2;
    localparam int unsigned REQ_ALU    = 3;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/shared_adder_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer (with wrap) wins; returns a one-hot grant and the encoded winner.
module shared_adder_arbiter_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    win_id,
    output logic               any
);

    int unsigned      idx;
    logic [ID_W-1:0]  sel;

    always_comb begin
        grant  = '0;
        win_id = '0;
        any    = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            sel = ID_W'(idx);
            if (!any && req[sel]) begin
                grant[sel] = 1'b1;
                win_id     = sel;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// Round-robin shared 32-bit add/subtract unit with one-cycle registered result
// tagged by requester ID. Define SHARED_ADDER_OVF_EN to add the Overflow output.
module shared_adder_arbiter
    import shared_adder_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter  int unsigned WIDTH   = DEF_WIDTH,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ-1:0]       SubOp,
    input  logic [NUM_REQ*WIDTH-1:0] OpA,
    input  logic [NUM_REQ*WIDTH-1:0] OpB,
    output logic [NUM_REQ-1:0]       Grant,
    output logic                     ResultValid,
    output logic [ID_W-1:0]          ResultId,
    output logic [WIDTH-1:0]         Result,
    output logic                     CarryOut
`ifdef SHARED_ADDER_OVF_EN
    ,
    output logic                     Overflow
`endif
);

    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    win_id;
    logic               pick_any;
    logic               granted;
    int unsigned        base;
    op_e                op_sel;
    logic [WIDTH-1:0]   opa_sel;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;

    shared_adder_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (Req),
        .ptr    (ptr),
        .grant  (pick_grant),
        .win_id (win_id),
        .any    (pick_any)
    );

    // Grant is gated by reset so nothing can be captured or remembered across it.
    assign Grant   = Reset ? pick_grant : '0;
    assign granted = pick_any & Reset;

    always_comb begin
        base    = 32'(win_id) * WIDTH;
        op_sel  = op_e'(SubOp[win_id]);
        opa_sel = OpA[base +: WIDTH];
        b_eff   = (op_sel == OP_SUB) ? ~OpB[base +: WIDTH] : OpB[base +: WIDTH];
        sum     = {1'b0, opa_sel} + {1'b0, b_eff}
                + {{WIDTH{1'b0}}, (op_sel == OP_SUB)};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ptr         <= '0;
            ResultValid <= 1'b0;
            ResultId    <= '0;
            Result      <= '0;
            CarryOut    <= 1'b0;
`ifdef SHARED_ADDER_OVF_EN
            Overflow    <= 1'b0;
`endif
        end else begin
            ResultValid <= granted;
            if (granted) begin
                ResultId <= win_id;
                Result   <= sum[WIDTH-1:0];
                CarryOut <= sum[WIDTH];
                ptr      <= (32'(win_id) == NUM_REQ - 1) ? '0 : win_id + ID_W'(1);
`ifdef SHARED_ADDER_OVF_EN
                // Same-sign adder inputs producing an opposite-sign result.
                Overflow <= (opa_sel[WIDTH-1] == b_eff[WIDTH-1]) &&
                            (sum[WIDTH-1] != opa_sel[WIDTH-1]);
`endif
            end
        end
    end

endmodule
